// File: rtl/uart_frame_rx.sv
// Purpose : 8N1 UART receiver with 0xFF-preamble frame alignment; delivers
//           4-byte frames {custom_cmd, cmd, data[15:8], data[7:0]}, MSB byte first.
// Latency : byte_valid 1 clk after the stop-bit mid-sample; frame_valid 1 clk after
//           the 4th byte_valid. Backpressure: none, strobes are fire-and-forget.
// Ports   : clk, reset_n (sync, active-low), rx (async serial in, idle high);
//           byte_valid/byte_data, frame_valid/frame_custom_cmd/frame_cmd/frame_data,
//           locked, err_framing, err_timeout, frame_cnt/err_cnt (statistics).
// Config  : define UART_FRAME_RX_STATS_EN to build frame_cnt/err_cnt counters;
//           otherwise both outputs are tied to zero.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 5000,
  parameter int SYNC_MIN     = 4,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_valid,
  output logic [7:0]  frame_custom_cmd,
  output logic [7:0]  frame_cmd,
  output logic [15:0] frame_data,
  output logic        locked,
  output logic        err_framing,
  output logic        err_timeout,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int SW       = $clog2(SYNC_MIN + 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] SYNC_MAX = SW'(SYNC_MIN);
  localparam logic [TW-1:0] TO_M1    = TW'(TO_LIMIT - 1);

  // ---------------------------------------------------------------- bit level
  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_WAIT} bit_state_t;

  bit_state_t    bstate;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Synchroniser resets to the idle level so reset exit never looks like a start edge.
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      bstate      <= B_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      err_framing <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      byte_valid  <= 1'b0;
      err_framing <= 1'b0;
      case (bstate)
        B_IDLE: begin
          if (rx_prev && !rx_sync) begin
            bstate  <= B_START;
            clk_cnt <= '0;
          end
        end
        B_START: begin
          // Half a bit in: a line back high means the low pulse was a glitch.
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            bstate  <= rx_sync ? B_IDLE : B_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) bstate <= B_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              bstate     <= B_IDLE;
            end else begin
              err_framing <= 1'b1;
              bstate      <= B_WAIT;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        B_WAIT: begin
          if (rx_sync) bstate <= B_IDLE;
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- frame level
  typedef enum logic {F_HUNT, F_LOCKED} frame_state_t;

  frame_state_t  fstate;
  logic [SW-1:0] sync_cnt;
  logic [1:0]    idx;
  logic [7:0]    b0, b1, b2;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fstate           <= F_HUNT;
      sync_cnt         <= '0;
      idx              <= '0;
      b0               <= '0;
      b1               <= '0;
      b2               <= '0;
      to_cnt           <= '0;
      frame_valid      <= 1'b0;
      frame_custom_cmd <= '0;
      frame_cmd        <= '0;
      frame_data       <= '0;
      err_timeout      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
      if (err_framing) begin
        fstate   <= F_HUNT;
        sync_cnt <= '0;
        idx      <= '0;
        to_cnt   <= '0;
      end else if (byte_valid) begin
        // A byte arriving on the expiry cycle still counts: it wins over the timeout.
        to_cnt <= '0;
        if (fstate == F_HUNT) begin
          if (byte_data == 8'hFF) begin
            if (sync_cnt != SYNC_MAX) sync_cnt <= sync_cnt + 1'b1;
          end else if (sync_cnt == SYNC_MAX) begin
            b0       <= byte_data;
            idx      <= 2'd1;
            sync_cnt <= '0;
            fstate   <= F_LOCKED;
          end else begin
            sync_cnt <= '0;
          end
        end else if (!(idx == 2'd0 && byte_data == 8'hFF)) begin
          // 0xFF in the byte-0 slot is inter-frame filler, never frame content.
          case (idx)
            2'd0: b0 <= byte_data;
            2'd1: b1 <= byte_data;
            2'd2: b2 <= byte_data;
            default: begin
              frame_custom_cmd <= b0;
              frame_cmd        <= b1;
              frame_data       <= {b2, byte_data};
              frame_valid      <= 1'b1;
            end
          endcase
          idx <= idx + 2'd1;
        end
      end else if (fstate == F_LOCKED && idx != 2'd0) begin
        if (to_cnt == TO_M1) begin
          err_timeout <= 1'b1;
          fstate      <= F_HUNT;
          sync_cnt    <= '0;
          idx         <= '0;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign locked = (fstate == F_LOCKED);

  // --------------------------------------------------------------- statistics
`ifdef UART_FRAME_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_valid)                frame_cnt <= frame_cnt + 16'd1;
      if (err_framing || err_timeout) err_cnt   <= err_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule
